// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble, one shift per clock).
// Latency: WIDTH cycles from the accepting edge to done; invalid input gives done on the next cycle.
// Backpressure: start is accepted only in IDLE/DONE; starts during SHIFT are dropped, not queued.
module bcd_to_bin #(
  parameter int DIGITS = 2,
  parameter int WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [WIDTH-1:0]    value
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             err_q, err_d;

  logic             in_bad;
  logic [BW-1:0]    sh_bcd;
  logic [BW-1:0]    corr_bcd;
  logic [WIDTH-1:0] sh_bin;

  // Flag an input word containing any nibble above 9
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // One right shift of {bcd, bin}, then subtract 3 from every shifted digit that is >= 8
  always_comb begin
    {sh_bcd, sh_bin} = {bcd_q, bin_q} >> 1;
    corr_bcd = sh_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd8) corr_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
    end
  end

  // Next-state logic: accept in IDLE/DONE, step the shifter in SHIFT, publish on the last step
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          bcd_d = bcd_in;
          bin_d = '0;
          cnt_d = CW'(WIDTH);
          err_d = 1'b0;
          if (in_bad) begin
            // Malformed digit: skip shifting and report a zero result with err
            state_d = ST_DONE;
            err_d   = 1'b1;
            value_d = '0;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        bcd_d = corr_bcd;
        bin_d = sh_bin;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          value_d = sh_bin;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any conversion silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign err   = err_q;
  assign value = value_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Testbench for bcd_to_bin: 2-digit and 3-digit instances checked against tables and a decimal model.
// Latency: checks WIDTH-cycle valid path and next-cycle invalid path.
// Backpressure: checks starts during SHIFT are ignored and DONE-cycle starts are accepted.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start2, start3;
  logic [7:0]  bcd2;
  logic [11:0] bcd3;
  logic        busy2, done2, err2;
  logic        busy3, done3, err3;
  logic [7:0]  value2;
  logic [9:0]  value3;

  int n_vec = 0;
  int n_bad = 0;
  int last_val2 = 0;

  always #5 clk = ~clk;

  bcd_to_bin #(.DIGITS(2), .WIDTH(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .bcd_in(bcd2),
    .busy(busy2), .done(done2), .err(err2), .value(value2)
  );

  bcd_to_bin #(.DIGITS(3), .WIDTH(10)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .bcd_in(bcd3),
    .busy(busy3), .done(done3), .err(err3), .value(value3)
  );

  typedef struct {
    logic [7:0] bcd;
    int         val;
    bit         bad;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal reference: weighted digit sum; any digit above 9 is an error with zero result
  function automatic void model(input logic [11:0] bcd, input int nd, output int val, output bit bad);
    int d;
    int scale;
    val = 0;
    bad = 1'b0;
    scale = 1;
    for (int i = 0; i < nd; i++) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      val += d * scale;
      scale *= 10;
    end
    if (bad) val = 0;
  endfunction

  // One conversion on the 2-digit instance; optional ignored-start glitch or held next start
  task automatic run2(input logic [7:0] bcd, input int exp_val, input bit exp_err,
                      input int glitch_at, input bit hold, input logic [7:0] next_bcd);
    int cyc;
    int busy_n;
    int exp_lat;
    bit stable;
    exp_lat = exp_err ? 0 : 8;
    @(negedge clk);
    start2 = 1'b1;
    bcd2   = bcd;
    @(posedge clk);
    @(negedge clk);
    if (hold) bcd2 = next_bcd;
    else      start2 = 1'b0;
    check("err_after_accept", int'(err2), int'(exp_err));
    cyc = 0;
    busy_n = 0;
    stable = 1'b1;
    while (!done2 && cyc < 40) begin
      if (busy2) busy_n++;
      if (int'(value2) != last_val2) stable = 1'b0;
      if (cyc == glitch_at) begin
        start2 = 1'b1;
        bcd2   = 8'h11;
      end else if (!hold) begin
        start2 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_latency", cyc, exp_lat);
    check("busy_cycles", busy_n, exp_lat);
    if (!exp_err) check("value_stable_while_busy", int'(stable), 1);
    check("value", int'(value2), exp_val);
    check("err", int'(err2), int'(exp_err));
    check("busy_at_done", int'(busy2), 0);
    last_val2 = exp_val;
    if (!hold) begin
      @(negedge clk);
      check("done_one_cycle", int'(done2), 0);
    end
  endtask

  // One conversion on the 3-digit instance
  task automatic run3(input logic [11:0] bcd, input int exp_val, input bit exp_err);
    int cyc;
    @(negedge clk);
    start3 = 1'b1;
    bcd3   = bcd;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    cyc = 0;
    while (!done3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("d3_done_latency", cyc, exp_err ? 0 : 10);
    check("d3_value", int'(value3), exp_val);
    check("d3_err", int'(err3), int'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[7];
    int   cyc;
    int   cnt;
    int   v;
    bit   b;
    logic [7:0]  r2;
    logic [11:0] r3;

    tbl[0] = '{8'h00, 8'h00, 1'b0};
    tbl[1] = '{8'h09, 8'h09, 1'b0};
    tbl[2] = '{8'h10, 8'h0A, 1'b0};
    tbl[3] = '{8'h59, 8'h3B, 1'b0};
    tbl[4] = '{8'h99, 8'h63, 1'b0};
    tbl[5] = '{8'h5A, 8'h00, 1'b1};
    tbl[6] = '{8'h23, 8'h17, 1'b0};

    rst = 1'b1;
    start2 = 1'b0; bcd2 = '0;
    start3 = 1'b0; bcd3 = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy2), 0);
    check("reset_done", int'(done2), 0);
    check("reset_err", int'(err2), 0);
    check("reset_value", int'(value2), 0);
    rst = 1'b0;

    // Table vectors, including invalid-digit then valid-clears-err
    for (int i = 0; i < 7; i++) begin
      run2(tbl[i].bcd, tbl[i].val, tbl[i].bad, -1, 1'b0, 8'h00);
    end

    // Reset in the middle of a conversion
    @(negedge clk);
    start2 = 1'b1;
    bcd2   = 8'h99;
    @(negedge clk);
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_busy", int'(busy2), 0);
    check("midreset_done", int'(done2), 0);
    check("midreset_err", int'(err2), 0);
    check("midreset_value", int'(value2), 0);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done2 || busy2) cnt++;
    end
    check("no_done_after_reset", cnt, 0);
    last_val2 = 0;
    run2(8'h47, 8'h2F, 1'b0, -1, 1'b0, 8'h00);

    // Start pulsed during SHIFT must be ignored
    run2(8'h42, 8'h2A, 1'b0, 2, 1'b0, 8'h00);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done2 || busy2) cnt++;
    end
    check("ignored_start_no_second_conv", cnt, 0);

    // Back-to-back: second start held through SHIFT into the DONE cycle
    run2(8'h12, 8'h0C, 1'b0, -1, 1'b1, 8'h34);
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    check("b2b_busy_after_done", int'(busy2), 1);
    check("b2b_done_dropped", int'(done2), 0);
    while (!done2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_done_spacing", cyc, 9);
    check("b2b_value", int'(value2), 8'h22);
    last_val2 = 8'h22;
    @(negedge clk);

    // Randomized 2-digit conversions against the decimal model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) r2 = 8'($urandom_range(0, 255));
      else r2 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      model({4'h0, r2}, 2, v, b);
      run2(r2, v, b, -1, 1'b0, 8'h00);
    end

    // Three-digit instance: directed then random
    run3(12'h999, 10'h3E7, 1'b0);
    run3(12'h500, 10'h1F4, 1'b0);
    run3(12'h0F0, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) r3 = 12'($urandom_range(0, 4095));
      else r3 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      model(r3, 3, v, b);
      run3(r3, v, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
